// File: rtl/leg_fetch.sv
// rtl/leg_fetch.sv - LEG instruction fetch stage: byte-wide memory reads assembled into 4-byte instructions
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_req, mem_addr             one-cycle byte read request to program memory
//   mem_rvalid, mem_rdata         read response (at least one cycle after the request)
//   inst_valid, inst_ready        instruction handshake towards the decoder
//   inst_opcode/arg1/arg2/dest    assembled instruction bytes 0..3
//   inst_pc                       address of byte 0 of the presented instruction
//   jump_taken, jump_target       redirect from execute; target is word-aligned internally
module leg_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [7:0]        inst_opcode,
    output logic [7:0]        inst_arg1,
    output logic [7:0]        inst_arg2,
    output logic [7:0]        inst_dest,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [1:0]        idx, idx_nx;
    logic [3:0][7:0]   inst_q;
    logic              pending;
    logic              capture;
    logic [ADDR_W-1:0] jump_pc;

    assign jump_pc    = jump_target & ~ADDR_W'(3);
    assign mem_addr   = pc + ADDR_W'(idx);
    assign inst_valid = (state == S_VALID);

    assign inst_opcode = inst_q[0];
    assign inst_arg1   = inst_q[1];
    assign inst_arg2   = inst_q[2];
    assign inst_dest   = inst_q[3];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        idx_nx   = idx;
        mem_req  = 1'b0;
        capture  = 1'b0;

        case (state)
            S_REQ: begin
                if (!jump_taken) begin
                    mem_req  = !rst;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid && !jump_taken) begin
                    capture = 1'b1;
                    if (idx == 2'd3) begin
                        state_nx = S_VALID;
                    end else begin
                        idx_nx   = idx + 2'd1;
                        state_nx = S_REQ;
                    end
                end
            end
            S_VALID: begin
                if (inst_ready && !jump_taken) begin
                    pc_nx    = pc + ADDR_W'(4);
                    idx_nx   = 2'd0;
                    state_nx = S_REQ;
                end
            end
            S_DRAIN: begin
                // A response that already arrived in the redirect cycle leaves
                // nothing to drain, so leave as soon as nothing is outstanding.
                if (mem_rvalid || !pending) begin
                    state_nx = S_REQ;
                end
            end
            default: ;
        endcase

        // Redirect overrides whatever the state above decided.
        if (jump_taken) begin
            pc_nx  = jump_pc;
            idx_nx = 2'd0;
            case (state)
                S_WAIT:  state_nx = S_DRAIN;
                S_VALID: state_nx = S_REQ;
                S_DRAIN: state_nx = S_DRAIN;
                default: state_nx = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            idx     <= 2'd0;
            pending <= 1'b0;
            inst_q  <= '0;
            inst_pc <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            idx   <= idx_nx;
            if (mem_req) begin
                pending <= 1'b1;
            end else if (mem_rvalid) begin
                pending <= 1'b0;
            end
            if (capture) begin
                inst_q[idx] <= mem_rdata;
            end
            if (state == S_WAIT && state_nx == S_VALID) begin
                inst_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_leg_fetch.sv
// tb/tb_leg_fetch.sv - self-checking bench for leg_fetch
module tb_leg_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_rvalid = 1'b0;
    logic [7:0] mem_rdata  = 8'h00;
    logic       inst_valid;
    logic       inst_ready;
    logic [7:0] inst_opcode, inst_arg1, inst_arg2, inst_dest;
    logic [7:0] inst_pc;
    logic       jump_taken;
    logic [7:0] jump_target;

    int total = 0;
    int bad   = 0;

    leg_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_arg1(inst_arg1),
        .inst_arg2(inst_arg2), .inst_dest(inst_dest),
        .inst_pc(inst_pc),
        .jump_taken(jump_taken), .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Program memory contents
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[8'h00] = 8'h20; mem[8'h01] = 8'h05; mem[8'h02] = 8'h07; mem[8'h03] = 8'h10;
        mem[8'h40] = 8'hAA; mem[8'h41] = 8'hBB; mem[8'h42] = 8'hCC; mem[8'h43] = 8'hDD;
        mem[8'hFC] = 8'h11; mem[8'hFD] = 8'h22; mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h44;
    end

    // Memory responder state and reference model state
    int         mem_lat = 1;
    int         cnt = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_addr = 8'h00;
    int         cyc = 0;
    logic [7:0] exp_pc = 8'h00;
    int         exp_k = 0;
    logic       have_prev = 1'b0;
    logic [39:0] prev = '0;
    logic [7:0] req_log [$];
    int         hs_cyc [$];

    // Model: every request must address the next byte of the current
    // instruction, every presented instruction must equal memory at its pc,
    // and a stalled instruction must not change.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_pc    = 8'h00;
            exp_k     = 0;
            have_prev = 1'b0;
        end else begin
            if (jump_taken) chk("jump_no_req", mem_req, 1'b0);
            if (mem_req) begin
                chk("one_outstanding", pend, 1'b0);
                chk("fetch_addr", mem_addr, 8'(exp_pc + exp_k));
                chk("fetch_count", exp_k < 4, 1'b1);
                exp_k++;
                pend      = 1'b1;
                cnt       = mem_lat;
                pend_addr = mem_addr;
                req_log.push_back(mem_addr);
            end
            if (inst_valid) begin
                chk("inst_pc_model", inst_pc, exp_pc);
                chk("bytes_fetched", exp_k, 4);
                chk("inst_model", {inst_opcode, inst_arg1, inst_arg2, inst_dest},
                    {mem[exp_pc], mem[8'(exp_pc + 1)], mem[8'(exp_pc + 2)], mem[8'(exp_pc + 3)]});
                if (have_prev)
                    chk("stall_stable", {inst_pc, inst_opcode, inst_arg1, inst_arg2, inst_dest} == prev, 1'b1);
            end
            if (jump_taken) begin
                exp_pc    = jump_target & 8'hFC;
                exp_k     = 0;
                have_prev = 1'b0;
            end else if (inst_valid && inst_ready) begin
                exp_pc    = exp_pc + 8'd4;
                exp_k     = 0;
                have_prev = 1'b0;
                hs_cyc.push_back(cyc);
            end else if (inst_valid) begin
                have_prev = 1'b1;
                prev      = {inst_pc, inst_opcode, inst_arg1, inst_arg2, inst_dest};
            end
        end
        // Drive the memory response one time unit after the next rising edge.
        #6;
        mem_rvalid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem[pend_addr];
                pend       = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!inst_valid && n < 200);
    endtask

    task automatic wait_hs(input int k);
        for (int i = 0; i < 400 && hs_cyc.size() < k; i++) step(1);
        chk("hs_count", hs_cyc.size() >= k, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; inst_ready = 1'b0; jump_taken = 1'b0; jump_target = 8'h00;
        step(3);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_bytes", {inst_opcode, inst_arg1, inst_arg2, inst_dest}, 32'h0);
        chk("rst_pc", inst_pc, 8'h00);

        // First instruction, 1-cycle memory
        rst = 1'b0;
        wait_valid(n);
        chk("first_valid_lat", n, 8);
        chk("first_opcode", inst_opcode, 8'h20);
        chk("first_arg1", inst_arg1, 8'h05);
        chk("first_arg2", inst_arg2, 8'h07);
        chk("first_dest", inst_dest, 8'h10);
        chk("first_pc", inst_pc, 8'h00);

        // Stall in VALID
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_valid", inst_valid, 1'b1);
            chk("stall_req", mem_req, 1'b0);
            chk("stall_opcode", inst_opcode, 8'h20);
        end
        inst_ready = 1'b1;
        step(1);
        inst_ready = 1'b0;
        chk("next_req", mem_req, 1'b1);
        chk("next_addr", mem_addr, 8'h04);

        // Redirect in WAIT with a coincident response
        step(1);
        chk("wait_rvalid", mem_rvalid, 1'b1);
        jump_taken = 1'b1; jump_target = 8'h42;
        step(1);
        jump_taken = 1'b0;
        #1;
        chk("drain_req", mem_req, 1'b0);
        step(1);
        chk("after_drain_req", mem_req, 1'b1);
        chk("after_drain_addr", mem_addr, 8'h40);
        wait_valid(n);
        chk("j40_valid", inst_valid, 1'b1);
        chk("j40_pc", inst_pc, 8'h40);
        chk("j40_inst", {inst_opcode, inst_arg1, inst_arg2, inst_dest}, 32'hAABBCCDD);

        // Redirect in VALID coincident with a handshake
        inst_ready = 1'b1; jump_taken = 1'b1; jump_target = 8'h80;
        step(1);
        inst_ready = 1'b0; jump_taken = 1'b0;
        #1;
        chk("j80_req", mem_req, 1'b1);
        chk("j80_addr", mem_addr, 8'h80);

        // Redirect in REQ to FEh: request suppressed, target aligned to FCh
        jump_taken = 1'b1; jump_target = 8'hFE;
        #1;
        chk("req_suppressed", mem_req, 1'b0);
        step(1);
        jump_taken = 1'b0;
        #1;
        chk("jfc_addr", mem_addr, 8'hFC);
        wait_valid(n);
        chk("jfc_pc", inst_pc, 8'hFC);
        chk("jfc_inst", {inst_opcode, inst_arg1, inst_arg2, inst_dest}, 32'h11223344);

        // Wrap from FCh to 00h
        req_log.delete();
        inst_ready = 1'b1;
        step(1);
        inst_ready = 1'b0;
        wait_valid(n);
        chk("wrap_nreq", req_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a;
            a = (req_log.size() > i) ? req_log[i] : 8'hXX;
            chk("wrap_addr", a, 8'(i));
        end
        chk("wrap_pc", inst_pc, 8'h00);

        // Back-to-back throughput, 1-cycle memory
        hs_cyc.delete();
        inst_ready = 1'b1;
        wait_hs(3);
        chk("tput_lat1_a", hs_cyc[1] - hs_cyc[0], 9);
        chk("tput_lat1_b", hs_cyc[2] - hs_cyc[1], 9);

        // 3-cycle memory latency
        mem_lat = 3;
        hs_cyc.delete();
        wait_hs(3);
        chk("tput_lat3_a", hs_cyc[1] - hs_cyc[0], 17);
        chk("tput_lat3_b", hs_cyc[2] - hs_cyc[1], 17);

        // Reset mid-fetch
        inst_ready = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        mem_lat = 1;
        chk("midrst_req", mem_req, 1'b0);
        rst = 1'b0;
        wait_valid(n);
        chk("midrst_lat", n, 8);
        chk("midrst_pc", inst_pc, 8'h00);
        chk("midrst_opcode", inst_opcode, 8'h20);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
